// File: rtl/ysyx_23060208_rd_arbiter.sv
// Two-master, one-slave AXI4 read arbiter: round-robin grant, one outstanding read,
// ID-routed responses, and a watchdog that fabricates an error reply.
module ysyx_23060208_rd_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clock,
   input  logic                  reset,

   input  logic                  m0_arvalid,
   output logic                  m0_arready,
   input  logic [ADDR_WIDTH-1:0] m0_araddr,
   input  logic [2:0]            m0_arsize,
   output logic                  m0_rvalid,
   input  logic                  m0_rready,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic [1:0]            m0_rresp,

   input  logic                  m1_arvalid,
   output logic                  m1_arready,
   input  logic [ADDR_WIDTH-1:0] m1_araddr,
   input  logic [2:0]            m1_arsize,
   output logic                  m1_rvalid,
   input  logic                  m1_rready,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic [1:0]            m1_rresp,

   output logic                  s_arvalid,
   input  logic                  s_arready,
   output logic [ADDR_WIDTH-1:0] s_araddr,
   output logic [2:0]            s_arsize,
   output logic [ID_WIDTH-1:0]   s_arid,
   output logic [7:0]            s_arlen,
   output logic [1:0]            s_arburst,
   input  logic                  s_rvalid,
   output logic                  s_rready,
   input  logic [DATA_WIDTH-1:0] s_rdata,
   input  logic [1:0]            s_rresp,
   input  logic [ID_WIDTH-1:0]   s_rid,
   input  logic                  s_rlast,

   output logic                  grant,
   output logic [1:0]            err_sticky
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] AR_WAIT = 2'd1;
   localparam logic [1:0] R_WAIT  = 2'd2;

   logic [1:0]            state_reg,     state_next;
   logic                  grant_reg,     grant_next;
   logic [ADDR_WIDTH-1:0] addr_reg,      addr_next;
   logic [2:0]            size_reg,      size_next;
   logic [ID_WIDTH-1:0]   arid_reg,      arid_next;
   logic                  s_arvalid_reg, s_arvalid_next;
   logic [7:0]            wd_cnt_reg,    wd_cnt_next;
   logic [1:0]            err_reg,       err_next;

   // Master-side signals gathered into index-addressable arrays
   logic [1:0]            m_arvalid;
   logic [1:0]            m_rready;
   logic [ADDR_WIDTH-1:0] m_araddr [2];
   logic [2:0]            m_arsize [2];
   logic [1:0]            m_arready;
   logic [1:0]            m_rvalid;
   logic [DATA_WIDTH-1:0] m_rdata  [2];
   logic [1:0]            m_rresp  [2];

   assign m_arvalid   = {m1_arvalid, m0_arvalid};
   assign m_rready    = {m1_rready, m0_rready};
   assign m_araddr[0] = m0_araddr;
   assign m_araddr[1] = m1_araddr;
   assign m_arsize[0] = m0_arsize;
   assign m_arsize[1] = m1_arsize;

   logic in_r;
   logic id_match;
   logic beat_hit;
   logic beat_drop;
   logic wd_fire;
   logic sel_rready;
   logic ar_hs;
   logic winner;

   assign in_r       = (state_reg == R_WAIT);
   assign id_match   = (s_rid == arid_reg);
   assign beat_hit   = in_r && s_rvalid && id_match;
   assign beat_drop  = in_r && s_rvalid && !id_match;
   assign wd_fire    = in_r && !beat_hit && (wd_cnt_reg == 8'(TIMEOUT));
   assign sel_rready = m_rready[grant_reg];
   assign ar_hs      = (state_reg == AR_WAIT) && s_arvalid_reg && s_arready;
   // On a tie the master that did not win last time goes next
   assign winner     = (&m_arvalid) ? !grant_reg : m_arvalid[1];

   always_comb begin
      state_next     = state_reg;
      grant_next     = grant_reg;
      addr_next      = addr_reg;
      size_next      = size_reg;
      arid_next      = arid_reg;
      s_arvalid_next = s_arvalid_reg;
      wd_cnt_next    = wd_cnt_reg;
      err_next       = err_reg;
      case (state_reg)
         IDLE: begin
            if (|m_arvalid) begin
               grant_next     = winner;
               addr_next      = m_araddr[winner];
               size_next      = m_arsize[winner];
               arid_next      = ID_WIDTH'(winner);
               s_arvalid_next = 1'b1;
               state_next     = AR_WAIT;
            end
         end
         AR_WAIT: begin
            if (ar_hs) begin
               s_arvalid_next = 1'b0;
               wd_cnt_next    = 8'd0;
               state_next     = R_WAIT;
            end
         end
         R_WAIT: begin
            if (beat_drop) begin
               err_next[0] = 1'b1;
            end
            if (beat_hit) begin
               if (sel_rready && s_rlast) begin
                  state_next = IDLE;
               end
            end else if (wd_fire) begin
               // Synthesised error reply stays up until the master takes it
               err_next[1] = 1'b1;
               if (sel_rready) begin
                  state_next = IDLE;
               end
            end else begin
               wd_cnt_next = wd_cnt_reg + 8'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         grant_reg     <= 1'b1;
         addr_reg      <= '0;
         size_reg      <= '0;
         arid_reg      <= '0;
         s_arvalid_reg <= 1'b0;
         wd_cnt_reg    <= 8'd0;
         err_reg       <= 2'b00;
      end else begin
         state_reg     <= state_next;
         grant_reg     <= grant_next;
         addr_reg      <= addr_next;
         size_reg      <= size_next;
         arid_reg      <= arid_next;
         s_arvalid_reg <= s_arvalid_next;
         wd_cnt_reg    <= wd_cnt_next;
         err_reg       <= err_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_master
         logic owns;
         assign owns          = (grant_reg == 1'(gi));
         assign m_arready[gi] = owns && ar_hs;
         assign m_rvalid[gi]  = owns && (beat_hit || wd_fire);
         assign m_rdata[gi]   = (owns && beat_hit) ? s_rdata : '0;
         assign m_rresp[gi]   = !owns   ? 2'b00 :
                                beat_hit ? s_rresp :
                                wd_fire  ? 2'b11 : 2'b00;
      end
   endgenerate

   assign m0_arready = m_arready[0];
   assign m1_arready = m_arready[1];
   assign m0_rvalid  = m_rvalid[0];
   assign m1_rvalid  = m_rvalid[1];
   assign m0_rdata   = m_rdata[0];
   assign m1_rdata   = m_rdata[1];
   assign m0_rresp   = m_rresp[0];
   assign m1_rresp   = m_rresp[1];

   assign s_arvalid  = s_arvalid_reg;
   assign s_araddr   = addr_reg;
   assign s_arsize   = size_reg;
   assign s_arid     = arid_reg;
   assign s_arlen    = 8'h00;
   assign s_arburst  = 2'b01;
   // Mismatched IDs are always drained so a stale beat cannot block the port
   assign s_rready   = in_r && (id_match ? sel_rready : 1'b1);

   assign grant      = grant_reg;
   assign err_sticky = err_reg;

endmodule
